// File: rtl/sort_buffer_if.sv
// Stream and status bundle for sort_buffer: batch size, input/output valid/ready streams, busy/done.
interface sort_buffer_if #(
  parameter int unsigned DATAWIDTH = 8
);
  logic [DATAWIDTH-1:0] count;
  logic [DATAWIDTH-1:0] inData;
  logic                 inValid;
  logic                 inReady;
  logic [DATAWIDTH-1:0] outData;
  logic                 outValid;
  logic                 outReady;
  logic                 busy;
  logic                 done;

  modport master (
    output count, inData, inValid, outReady,
    input  inReady, outData, outValid, busy, done
  );

  modport slave (
    input  count, inData, inValid, outReady,
    output inReady, outData, outValid, busy, done
  );
endinterface

// File: rtl/sort_buffer.sv
// Batch sorter: loads N words, odd-even transposition sorts them, streams them out ascending.
// Optional SORT_BUFFER_EARLY_EXIT_EN: leave SORT after an even and an odd pass both without swaps.
module sort_buffer #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned DEPTH     = 8
) (
  input  logic         clk,
  input  logic         rst,
  sort_buffer_if.slave bus
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StSort, StDrain} state_e;

  state_e               state_q;
  logic [DATAWIDTH-1:0] mem_q  [DEPTH];
  logic [DATAWIDTH-1:0] sort_d [DEPTH];
  logic [AddrW-1:0]     last_q, last_d;
  logic [AddrW-1:0]     w_idx_q, r_idx_q, p_idx_q;
  logic                 in_ready_q, out_valid_q, busy_q;
  logic [DATAWIDTH-1:0] out_data_q;
  logic                 load_hs, drain_hs, sort_exit;
`ifdef SORT_BUFFER_EARLY_EXIT_EN
  logic                 any_swap;
  logic                 prev_clean_q;
`endif

  // Batch size is stored as the index of the last slot (N-1).
  assign last_d = ((bus.count == '0) || (bus.count > DATAWIDTH'(DEPTH))) ?
                  AddrW'(DEPTH - 1) : AddrW'(bus.count - DATAWIDTH'(1));

  assign load_hs  = (state_q == StLoad) && in_ready_q && bus.inValid;
  assign drain_hs = (state_q == StDrain) && out_valid_q && bus.outReady;

  // One transposition pass; pairs are disjoint so each reads only the current contents.
  always_comb begin
    sort_d = mem_q;
`ifdef SORT_BUFFER_EARLY_EXIT_EN
    any_swap = 1'b0;
`endif
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      if ((i[0] == p_idx_q[0]) && (AddrW'(i) < last_q) && (mem_q[i] > mem_q[i+1])) begin
        sort_d[i]   = mem_q[i+1];
        sort_d[i+1] = mem_q[i];
`ifdef SORT_BUFFER_EARLY_EXIT_EN
        any_swap    = 1'b1;
`endif
      end
    end
  end

`ifdef SORT_BUFFER_EARLY_EXIT_EN
  assign sort_exit = (p_idx_q == last_q) ||
                     ((p_idx_q != '0) && !any_swap && prev_clean_q);
`else
  assign sort_exit = (p_idx_q == last_q);
`endif

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_hs) begin
      mem_q[w_idx_q] <= bus.inData;
    end else if (state_q == StSort) begin
      mem_q <= sort_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_q       <= '0;
      w_idx_q      <= '0;
      r_idx_q      <= '0;
      p_idx_q      <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      busy_q       <= 1'b0;
`ifdef SORT_BUFFER_EARLY_EXIT_EN
      prev_clean_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          last_q       <= last_d;
          w_idx_q      <= '0;
          r_idx_q      <= '0;
          p_idx_q      <= '0;
          in_ready_q   <= 1'b1;
          busy_q       <= 1'b1;
`ifdef SORT_BUFFER_EARLY_EXIT_EN
          prev_clean_q <= 1'b0;
`endif
          state_q      <= StLoad;
        end
        StLoad: begin
          if (load_hs) begin
            w_idx_q <= w_idx_q + AddrW'(1);
            if (w_idx_q == last_q) begin
              in_ready_q <= 1'b0;
              state_q    <= StSort;
            end
          end
        end
        StSort: begin
          p_idx_q      <= p_idx_q + AddrW'(1);
`ifdef SORT_BUFFER_EARLY_EXIT_EN
          prev_clean_q <= !any_swap;
`endif
          if (sort_exit) begin
            // Slot 0 comes from this pass's result, not the pre-pass storage.
            out_data_q  <= sort_d[0];
            out_valid_q <= 1'b1;
            state_q     <= StDrain;
          end
        end
        StDrain: begin
          if (drain_hs) begin
            if (r_idx_q == last_q) begin
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              state_q     <= StIdle;
            end else begin
              r_idx_q    <= r_idx_q + AddrW'(1);
              out_data_q <= mem_q[r_idx_q + AddrW'(1)];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.inReady  = in_ready_q;
  assign bus.outValid = out_valid_q;
  assign bus.outData  = out_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = drain_hs && (r_idx_q == last_q);

endmodule

// File: tb/tb_sort_buffer.sv
// Directed bench for sort_buffer: reset, sizing, stalls, early exit, input gaps and count changes.
module tb_sort_buffer;

  logic clk = 1'b0;
  logic rst;
  int   vec  = 0;
  int   errs = 0;
  int   sc;

  logic [7:0] din  [8];
  logic [7:0] dexp [8];

  sort_buffer_if #(.DATAWIDTH(8)) bus ();

  sort_buffer #(.DATAWIDTH(8), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input logic [7:0] v);
    int t = 0;
    bus.inValid = 1'b1;
    bus.inData  = v;
    while (bus.inReady !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("push_ready", bus.inReady, 1);
    @(negedge clk);
    bus.inValid = 1'b0;
  endtask

  task automatic push_batch(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      push(din[i]);
    end
  endtask

  task automatic wait_sort(output int c);
    c = 0;
    while (bus.outValid !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic pop_all(input int n, input bit stall, input string tag);
    int cyc = 0;
    int k   = 0;
    while (k < n && cyc < 300) begin
      bus.outReady = stall ? ((cyc % 3) == 0) : 1'b1;
      #1;
      if (bus.outValid === 1'b1) begin
        chk({tag, "_data"}, bus.outData, dexp[k]);
        if (bus.outReady) begin
          chk({tag, "_done"}, bus.done, (k == n - 1));
          k++;
        end else begin
          chk({tag, "_stall_done"}, bus.done, 0);
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.outReady = 1'b0;
    chk({tag, "_words"}, k, n);
    chk({tag, "_idle_busy"}, bus.busy, 0);
    chk({tag, "_idle_valid"}, bus.outValid, 0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.count    = 8'd8;
    bus.inData   = '0;
    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_inReady", bus.inReady, 0);
    chk("rst_outValid", bus.outValid, 0);
    chk("rst_outData", bus.outData, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    #1 chk("idle_inReady", bus.inReady, 0);
    @(negedge clk);
    chk("load_inReady", bus.inReady, 1);
    chk("load_busy", bus.busy, 1);

    // Abort mid-load after 3 words
    push(8'd11); push(8'd22); push(8'd33);
    rst = 1'b1;
    #1;
    chk("abort_inReady", bus.inReady, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_outValid", bus.outValid, 0);
    chk("abort_outData", bus.outData, 0);
    chk("abort_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_idle_inReady", bus.inReady, 0);
    @(negedge clk);
    chk("rel_load_inReady", bus.inReady, 1);

    // Full batch of 8 with mixed values
    din  = '{8'd7, 8'd3, 8'd0, 8'd255, 8'd3, 8'd128, 8'd1, 8'd64};
    dexp = '{8'd0, 8'd1, 8'd3, 8'd3, 8'd7, 8'd64, 8'd128, 8'd255};
    push_batch(8, 1'b0);
    chk("full_inReady_low", bus.inReady, 0);
    pop_all(8, 1'b0, "mixed");

    // count=0 means DEPTH
    bus.count = 8'd0;
    din  = '{8'd200, 8'd10, 8'd50, 8'd10, 8'd0, 8'd255, 8'd99, 8'd1};
    dexp = '{8'd0, 8'd1, 8'd10, 8'd10, 8'd50, 8'd99, 8'd200, 8'd255};
    push_batch(8, 1'b0);
    pop_all(8, 1'b0, "cnt0");

    // count above DEPTH clamps to DEPTH
    bus.count = 8'd200;
    din  = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    dexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    push_batch(8, 1'b0);
    pop_all(8, 1'b0, "cnt200");

    // Single-word batch
    bus.count = 8'd1;
    din[0]  = 8'd42;
    dexp[0] = 8'd42;
    push_batch(1, 1'b0);
    wait_sort(sc);
    chk("n1_sort_cycles", sc, 1);
    pop_all(1, 1'b0, "n1");

    // Partial batch with output stalls
    bus.count = 8'd5;
    din  = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    dexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0};
    push_batch(5, 1'b0);
    chk("n5_inReady_low", bus.inReady, 0);
    pop_all(5, 1'b1, "stall");

    // Already sorted input: sort length depends on early exit
    bus.count = 8'd8;
    din  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    dexp = din;
    push_batch(8, 1'b0);
    wait_sort(sc);
`ifdef SORT_BUFFER_EARLY_EXIT_EN
    chk("sorted_sort_cycles", sc, 2);
`else
    chk("sorted_sort_cycles", sc, 8);
`endif
    pop_all(8, 1'b0, "sorted");

    // Input gaps, then count changed during drain
    din  = '{8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0, 8'd255, 8'd128};
    dexp = '{8'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd128, 8'd255};
    push_batch(8, 1'b1);
    wait_sort(sc);
    bus.count = 8'd4;
    pop_all(8, 1'b0, "gaps");

    din  = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    dexp = '{8'd1, 8'd1, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    push_batch(4, 1'b0);
    chk("n4_inReady_low", bus.inReady, 0);
    pop_all(4, 1'b0, "next4");

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
